// File: rtl/clic_pkg.sv
// Shared CLIC definitions: interrupt trigger attribute encoding used by the
// register adapter, the arbiter and the pending-bit controller.
package clic_pkg;

    localparam int unsigned TRIG_EDGE_BIT = 0;
    localparam int unsigned TRIG_NEG_BIT  = 1;

    typedef enum logic [1:0] {
        TRIG_LEVEL_POS = 2'b00,
        TRIG_EDGE_POS  = 2'b01,
        TRIG_LEVEL_NEG = 2'b10,
        TRIG_EDGE_NEG  = 2'b11
    } trig_e;

    function automatic logic trig_is_edge(input logic [1:0] trig);
        return trig[TRIG_EDGE_BIT];
    endfunction

    function automatic logic trig_is_neg(input logic [1:0] trig);
        return trig[TRIG_NEG_BIT];
    endfunction

endpackage

// File: rtl/clic_ip_cell.sv
// One interrupt source: synchronizer chain, previous-sample flop, edge/level
// qualification and the pending-bit flop.
module clic_ip_cell
    import clic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       src_i,
    input  logic [1:0] trig_i,
    input  logic       sw_we_i,
    input  logic       sw_wdata_i,
    input  logic       ack_hit_i,
    output logic       ip_o
);

    logic src_s;
    logic src_prev_q, src_prev_d;
    logic ip_q, ip_d;
    logic act, evt, is_edge, is_neg;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign src_s = src_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d    = sync_q << 1;
            sync_d[0] = src_i;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign src_s = sync_q[SYNC_STAGES-1];
    end

    assign is_edge = trig_is_edge(trig_i);
    assign is_neg  = trig_is_neg(trig_i);
    assign act     = src_s ^ is_neg;
    // Edge is judged on the raw samples so a polarity flip on a static line
    // never looks like a transition.
    assign evt     = is_neg ? (~src_s & src_prev_q) : (src_s & ~src_prev_q);

    always_comb begin
        src_prev_d = src_s;
        ip_d       = ip_q;
        if (is_edge) begin
            if (sw_we_i) begin
                ip_d = sw_wdata_i;
            end else if (evt) begin
                ip_d = 1'b1;
            end else if (ack_hit_i) begin
                ip_d = 1'b0;
            end
        end else begin
            ip_d = act;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_prev_q <= 1'b0;
            ip_q       <= 1'b0;
        end else begin
            src_prev_q <= src_prev_d;
            ip_q       <= ip_d;
        end
    end

    assign ip_o = ip_q;

endmodule

// File: rtl/clic_ip_ctrl.sv
// Hardware writer of the per-source CLIC interrupt-pending bits: acknowledge
// decode plus one clic_ip_cell per source.
module clic_ip_ctrl
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IdWidth     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] pol_i,
    input  logic [N_SOURCE-1:0] ip_sw_we_i,
    input  logic [N_SOURCE-1:0] ip_sw_wdata_i,
    input  logic                irq_ack_i,
    input  logic [IdWidth-1:0]  irq_ack_id_i,
    output logic [N_SOURCE-1:0] ip_o
);

    logic [N_SOURCE-1:0] ack_hit;

    // Ids at or beyond N_SOURCE have no matching index and fall through.
    always_comb begin
        ack_hit = '0;
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            ack_hit[i] = irq_ack_i && (32'(irq_ack_id_i) == i);
        end
    end

    for (genvar g = 0; g < N_SOURCE; g++) begin : g_src
        logic [1:0] trig;

        always_comb begin
            trig                = '0;
            trig[TRIG_EDGE_BIT] = le_i[g];
            trig[TRIG_NEG_BIT]  = pol_i[g];
        end

        clic_ip_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (intr_src_i[g]),
            .trig_i     (trig),
            .sw_we_i    (ip_sw_we_i[g]),
            .sw_wdata_i (ip_sw_wdata_i[g]),
            .ack_hit_i  (ack_hit[g]),
            .ip_o       (ip_o[g])
        );
    end

endmodule

// File: tb/tb_clic_ip_ctrl.sv
// Bench for clic_ip_ctrl: directed latency/priority scenarios followed by a
// randomized run against a delay-line reference model of the pending bits.
module tb_clic_ip_ctrl;

    localparam int unsigned N  = 30;
    localparam int unsigned S  = 2;
    localparam int unsigned IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  src = '0, le = '0, pol = '0, we = '0, wd = '0;
    logic          ack = 1'b0;
    logic [IW-1:0] ack_id = '0;
    logic [N-1:0]  ip;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [N-1:0] m_ip;
    logic [N-1:0] hist[$];

    always #5 clk = ~clk;

    clic_ip_ctrl #(
        .N_SOURCE    (N),
        .SYNC_STAGES (S),
        .IdWidth     (IW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .intr_src_i    (src),
        .le_i          (le),
        .pol_i         (pol),
        .ip_sw_we_i    (we),
        .ip_sw_wdata_i (wd),
        .irq_ack_i     (ack),
        .irq_ack_id_i  (ack_id),
        .ip_o          (ip)
    );

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ip = '0;
        hist.delete();
        for (int i = 0; i < int'(S) + 2; i++) hist.push_back('0);
    endfunction

    // Synchronized view is the input S clocks old; the previous sample is one older.
    function automatic void model_clock();
        logic [N-1:0] s, p;
        hist.push_front(src);
        void'(hist.pop_back());
        s = hist[S];
        p = hist[S + 1];
        for (int i = 0; i < int'(N); i++) begin
            logic rise, fall, evt, hit;
            rise = s[i] && !p[i];
            fall = !s[i] && p[i];
            evt  = pol[i] ? fall : rise;
            hit  = ack && (int'(ack_id) == i);
            if (!le[i])      m_ip[i] = s[i] ^ pol[i];
            else if (we[i])  m_ip[i] = wd[i];
            else if (evt)    m_ip[i] = 1'b1;
            else if (hit)    m_ip[i] = 1'b0;
        end
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_clock();
        check_eq(tag, ip, m_ip);
    endtask

    function automatic logic [N-1:0] bit_mask(input int i);
        logic [N-1:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [N-1:0] m3, m5, m2;
        m3 = bit_mask(3);
        m5 = bit_mask(5);
        m2 = bit_mask(2);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", ip, '0);
        rst_n = 1'b1;

        // Level, positive: three-cycle latency on rise and fall; acks ignored.
        src[3] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            ack = 1'b1;
            ack_id = IW'(3);
            step("lvl");
            check_eq("lvl_rise_b3", ip & m3, (c >= 3) ? m3 : '0);
        end
        ack = 1'b0;
        src[3] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step("lvl");
            check_eq("lvl_fall_b3", ip & m3, (c >= 3) ? '0 : m3);
        end

        // Edge, positive: one-cycle pulse is latched and held until ack.
        le[5] = 1'b1;
        src[5] = 1'b1;
        step("edge");
        src[5] = 1'b0;
        step("edge");
        step("edge");
        check_eq("edge_set_b5", ip & m5, m5);
        repeat (5) step("edge");
        check_eq("edge_hold_b5", ip & m5, m5);
        ack = 1'b1;
        ack_id = IW'(5);
        step("edge");
        ack = 1'b0;
        check_eq("edge_ack_b5", ip & m5, '0);

        // Software write of 0 beats a same-cycle edge; then write 1.
        le[2] = 1'b1;
        src[2] = 1'b1;
        step("sw");
        step("sw");
        we[2] = 1'b1;
        wd[2] = 1'b0;
        step("sw");
        check_eq("sw_beats_evt_b2", ip & m2, '0);
        we[2] = 1'b0;
        repeat (2) step("sw");
        we[2] = 1'b1;
        wd[2] = 1'b1;
        step("sw");
        we = '0;
        check_eq("sw_set_b2", ip & m2, m2);

        // All pending via software, then out-of-range acks change nothing.
        le = '1;
        src = '0;
        repeat (4) step("badid");
        we = '1;
        wd = '1;
        step("badid");
        we = '0;
        ack = 1'b1;
        ack_id = IW'(30);
        step("badid");
        check_eq("ack_id30", ip, '1);
        ack_id = IW'(31);
        step("badid");
        ack = 1'b0;
        check_eq("ack_id31", ip, '1);

        // Asynchronous reset mid-cycle with bits pending.
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", ip, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Randomized run, with a second asynchronous reset in the middle.
        le  = N'($urandom);
        pol = N'($urandom);
        for (int c = 0; c < 2000; c++) begin
            src ^= N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) le  ^= N'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) pol ^= N'($urandom & $urandom);
            we     = N'($urandom & $urandom & $urandom & $urandom);
            wd     = N'($urandom);
            ack    = ($urandom_range(0, 2) == 0);
            ack_id = IW'($urandom_range(0, 31));
            if (c == 1000) begin
                #2 rst_n = 1'b0;
                #1 check_eq("rand_rst", ip, '0);
                model_reset();
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
